// File: rtl/sdram_client_bridge.sv
// sdram_client_bridge: host-side front end for the SDRAM controller top.
// Takes host word-burst commands, stages write and read data in two FIFOs,
// and drives the controller's req/ack burst interface.
// Optional build macro: SDRAM_BRIDGE_PAGE_CHECK_EN rejects bursts that
// cross a 512-word column page.
module sdram_client_bridge #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [23:0] cmd_addr,
  input  logic [8:0]  cmd_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [15:0] wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [15:0] rdata,
  output logic        err,
  output logic [23:0] sdram_wr_addr,
  output logic [23:0] sdram_rd_addr,
  output logic [15:0] sdram_wr_data,
  input  logic [15:0] sdram_rd_data,
  output logic        sdram_wr_req,
  output logic        sdram_rd_req,
  output logic [8:0]  sdwr_bytes,
  output logic [8:0]  sdrd_bytes,
  input  logic        sdram_wr_ack,
  input  logic        sdram_rd_ack,
  input  logic        sdram_init_done,
  input  logic        sdram_busy
);

  localparam int unsigned    AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned    CW        = AW + 1;
  localparam logic [9:0]     DEPTH10   = 10'(FIFO_DEPTH);
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WFILL, S_WREQ, S_WDATA, S_RSPACE, S_RREQ, S_RDATA
  } state_t;

  state_t          r_state, w_next;

  logic [23:0]     r_addr;
  logic [8:0]      r_len;
  logic [8:0]      r_left;
  logic            r_err;
  logic            r_wr_req;
  logic            r_rd_req;

  logic [15:0]     r_wmem [FIFO_DEPTH];
  logic [AW-1:0]   r_wf_wptr, r_wf_rptr;
  logic [CW-1:0]   r_wf_cnt;
  logic [15:0]     r_rmem [FIFO_DEPTH];
  logic [AW-1:0]   r_rf_wptr, r_rf_rptr;
  logic [CW-1:0]   r_rf_cnt;

  logic w_accept, w_len_bad, w_page_bad, w_drop;
  logic w_wf_full, w_rf_empty, w_wfill_ok, w_rspace_ok;
  logic w_wr_phase, w_rd_phase;
  logic w_wpush, w_wpop, w_rpush, w_rpop, w_wr_extra, w_rd_extra;

  assign w_wf_full   = (r_wf_cnt == DEPTH_CNT);
  assign w_rf_empty  = (r_rf_cnt == '0);
  assign wdata_ready = !w_wf_full;
  assign rdata_valid = !w_rf_empty;
  assign rdata       = r_rmem[r_rf_rptr];
  assign sdram_wr_data = r_wmem[r_wf_rptr];

  assign w_wpush = wdata_valid & !w_wf_full;
  assign w_rpop  = rdata_ready & !w_rf_empty;

  // The first ack seen while still requesting already moves data.
  assign w_wr_phase = (r_state == S_WREQ) || (r_state == S_WDATA);
  assign w_rd_phase = (r_state == S_RREQ) || (r_state == S_RDATA);
  assign w_wpop     = w_wr_phase & sdram_wr_ack & (r_left != '0) & (r_wf_cnt != '0);
  assign w_wr_extra = w_wr_phase & sdram_wr_ack & (r_left == '0);
  assign w_rpush    = w_rd_phase & sdram_rd_ack & (r_left != '0) & (r_rf_cnt != DEPTH_CNT);
  assign w_rd_extra = w_rd_phase & sdram_rd_ack & (r_left == '0);

  assign w_len_bad = (cmd_len == '0) || ({1'b0, cmd_len} > DEPTH10);
`ifdef SDRAM_BRIDGE_PAGE_CHECK_EN
  assign w_page_bad = ({1'b0, cmd_addr[8:0]} + {1'b0, cmd_len}) > 10'd512;
`else
  assign w_page_bad = 1'b0;
`endif
  assign w_drop   = w_len_bad | w_page_bad;
  assign w_accept = cmd_valid & cmd_ready;

  assign w_wfill_ok  = {{(10-CW){1'b0}}, r_wf_cnt} >= {1'b0, r_len};
  assign w_rspace_ok = (DEPTH10 - {{(10-CW){1'b0}}, r_rf_cnt}) >= {1'b0, r_len};

  assign sdram_wr_addr = r_addr;
  assign sdram_rd_addr = r_addr;
  assign sdwr_bytes    = r_len;
  assign sdrd_bytes    = r_len;
  assign sdram_wr_req  = r_wr_req;
  assign sdram_rd_req  = r_rd_req;
  assign err           = r_err;

  // FSM state register.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state and command handshake.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = sdram_init_done & !sdram_busy;
        if (cmd_valid && cmd_ready && !w_drop)
          w_next = cmd_wr ? S_WFILL : S_RSPACE;
      end
      S_WFILL:  if (w_wfill_ok)   w_next = S_WREQ;
      S_WREQ:   if (sdram_wr_ack) w_next = S_WDATA;
      S_WDATA:  if (!sdram_wr_ack) w_next = S_IDLE;
      S_RSPACE: if (w_rspace_ok)  w_next = S_RREQ;
      S_RREQ:   if (sdram_rd_ack) w_next = S_RDATA;
      S_RDATA:  if (!sdram_rd_ack) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Command latch, remaining-word counter, registered requests, sticky error.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_left   <= '0;
      r_err    <= 1'b0;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
    end else begin
      r_wr_req <= (w_next == S_WREQ);
      r_rd_req <= (w_next == S_RREQ);
      if (w_accept && !w_drop) begin
        r_addr <= cmd_addr;
        r_len  <= cmd_len;
        r_left <= cmd_len;
      end else if (w_wpop || w_rpush) begin
        r_left <= r_left - 1'b1;
      end
      if ((w_accept && w_drop) || w_wr_extra || w_rd_extra)
        r_err <= 1'b1;
    end
  end

  // Write FIFO; storage is cleared so the head output reads 0 out of reset.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      r_wf_wptr <= '0;
      r_wf_rptr <= '0;
      r_wf_cnt  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_wmem[AW'(i)] <= '0;
    end else begin
      if (w_wpush) begin
        r_wmem[r_wf_wptr] <= wdata;
        r_wf_wptr         <= r_wf_wptr + 1'b1;
      end
      if (w_wpop) r_wf_rptr <= r_wf_rptr + 1'b1;
      case ({w_wpush, w_wpop})
        2'b10:   r_wf_cnt <= r_wf_cnt + 1'b1;
        2'b01:   r_wf_cnt <= r_wf_cnt - 1'b1;
        default: r_wf_cnt <= r_wf_cnt;
      endcase
    end
  end

  // Read FIFO; host pops run independently of the FSM.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      r_rf_wptr <= '0;
      r_rf_rptr <= '0;
      r_rf_cnt  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_rmem[AW'(i)] <= '0;
    end else begin
      if (w_rpush) begin
        r_rmem[r_rf_wptr] <= sdram_rd_data;
        r_rf_wptr         <= r_rf_wptr + 1'b1;
      end
      if (w_rpop) r_rf_rptr <= r_rf_rptr + 1'b1;
      case ({w_rpush, w_rpop})
        2'b10:   r_rf_cnt <= r_rf_cnt + 1'b1;
        2'b01:   r_rf_cnt <= r_rf_cnt - 1'b1;
        default: r_rf_cnt <= r_rf_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_client_bridge.sv
// Directed self-checking bench for sdram_client_bridge (FIFO_DEPTH = 16).
module tb_sdram_client_bridge;

  logic        clk_100m = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [23:0] cmd_addr = '0;
  logic [8:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [15:0] wdata = '0;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [15:0] rdata;
  logic        err;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic [15:0] sdram_wr_data;
  logic [15:0] sdram_rd_data = '0;
  logic        sdram_wr_req, sdram_rd_req;
  logic [8:0]  sdwr_bytes, sdrd_bytes;
  logic        sdram_wr_ack = 1'b0;
  logic        sdram_rd_ack = 1'b0;
  logic        sdram_init_done = 1'b0;
  logic        sdram_busy = 1'b0;

  int errors = 0;
  int checks = 0;

  sdram_client_bridge #(.FIFO_DEPTH(16)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .err(err),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
    .sdram_wr_data(sdram_wr_data), .sdram_rd_data(sdram_rd_data),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdwr_bytes(sdwr_bytes), .sdrd_bytes(sdrd_bytes),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_init_done(sdram_init_done), .sdram_busy(sdram_busy)
  );

  always #5 clk_100m = ~clk_100m;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [15:0] d);
    wdata_valid = 1'b1;
    wdata       = d;
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic wr, input logic [23:0] a, input logic [8:0] l);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input logic wr, output logic ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      if ((wr ? sdram_wr_req : sdram_rd_req) === 1'b1) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    sdram_init_done = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({cmd_ready, rdata_valid, err, sdram_wr_req, sdram_rd_req} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {cmd_ready, rdata_valid, err, sdram_wr_req, sdram_rd_req});
    end
    checks++;
    if (wdata_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wdata_ready: got %b expected 1", wdata_ready);
    end
    checks++;
    if ({rdata, sdram_wr_data} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00000000", {rdata, sdram_wr_data});
    end
    checks++;
    if ({sdram_wr_addr, sdram_rd_addr, sdwr_bytes, sdrd_bytes} !== 66'h0) begin
      errors++;
      $display("FAIL reset_addr_len: got %h expected 0",
               {sdram_wr_addr, sdram_rd_addr, sdwr_bytes, sdrd_bytes});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_not_ready();
    sdram_init_done = 1'b0;
    sdram_busy      = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL nr_init: got %b expected 0", cmd_ready);
    end
    sdram_init_done = 1'b1;
    sdram_busy      = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL nr_busy: got %b expected 0", cmd_ready);
    end
    sdram_busy = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL nr_ready: got %b expected 1", cmd_ready);
    end
    tick();
  endtask

  task automatic test_write_burst();
    logic ok;
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) push_word(16'hA001 + 16'(i));
    send_cmd(1'b1, 24'h000010, 9'd4);
    checks++;
    if ({sdwr_bytes, sdram_wr_addr} !== {9'd4, 24'h000010}) begin
      errors++;
      $display("FAIL wr_latch: got bytes=%0d addr=%h expected bytes=4 addr=000010",
               sdwr_bytes, sdram_wr_addr);
    end
    wait_req(1'b1, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL wr_req_timeout: got req=%b expected 1", sdram_wr_req);
    end
    for (int i = 0; i < 4; i++) begin
      sdram_wr_ack = 1'b1;
      exp = 16'hA001 + 16'(i);
      #1;
      checks++;
      if (sdram_wr_data !== exp) begin
        errors++;
        $display("FAIL wr_data_%0d: got %h expected %h", i, sdram_wr_data, exp);
      end
      tick();
      if (i == 0) begin
        checks++;
        if (sdram_wr_req !== 1'b0) begin
          errors++;
          $display("FAIL wr_req_drop: got %b expected 0", sdram_wr_req);
        end
      end
    end
    sdram_wr_ack = 1'b0;
    tick();
    checks++;
    if ({cmd_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL wr_done: got ready=%b err=%b expected ready=1 err=0", cmd_ready, err);
    end
  endtask

  task automatic test_illegal_len();
    send_cmd(1'b1, 24'h0, 9'd0);
    checks++;
    if ({err, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL len0_err: got err=%b ready=%b expected 1 1", err, cmd_ready);
    end
    tick();
    tick();
    checks++;
    if (sdram_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL len0_req: got %b expected 0", sdram_wr_req);
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", err);
    end
    send_cmd(1'b0, 24'h0, 9'd17);
    checks++;
    if ({err, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL len17_err: got err=%b ready=%b expected 1 1", err, cmd_ready);
    end
    tick();
    tick();
    checks++;
    if (sdram_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL len17_req: got %b expected 0", sdram_rd_req);
    end
  endtask

  task automatic test_extra_acks();
    logic ok;
    do_reset();
    push_word(16'hC001);
    push_word(16'hC002);
    push_word(16'hC003);
    send_cmd(1'b1, 24'h000100, 9'd2);
    wait_req(1'b1, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL xa_req_timeout: got req=%b expected 1", sdram_wr_req);
    end
    sdram_wr_ack = 1'b1;
    #1;
    checks++;
    if (sdram_wr_data !== 16'hC001) begin
      errors++;
      $display("FAIL xa_data0: got %h expected C001", sdram_wr_data);
    end
    tick();
    checks++;
    if (sdram_wr_data !== 16'hC002) begin
      errors++;
      $display("FAIL xa_data1: got %h expected C002", sdram_wr_data);
    end
    tick();
    checks++;
    if ({err, sdram_wr_data} !== {1'b0, 16'hC003}) begin
      errors++;
      $display("FAIL xa_third: got err=%b data=%h expected err=0 data=C003", err, sdram_wr_data);
    end
    tick();
    checks++;
    if ({err, sdram_wr_data} !== {1'b1, 16'hC003}) begin
      errors++;
      $display("FAIL xa_extra: got err=%b data=%h expected err=1 data=C003", err, sdram_wr_data);
    end
    sdram_wr_ack = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL xa_idle: got %b expected 1", cmd_ready);
    end
    send_cmd(1'b1, 24'h000200, 9'd1);
    wait_req(1'b1, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL xa_left_req: got req=%b expected 1", sdram_wr_req);
    end
    sdram_wr_ack = 1'b1;
    #1;
    checks++;
    if (sdram_wr_data !== 16'hC003) begin
      errors++;
      $display("FAIL xa_left_data: got %h expected C003", sdram_wr_data);
    end
    tick();
    sdram_wr_ack = 1'b0;
    tick();
  endtask

  task automatic test_read_full();
    logic ok;
    logic [15:0] exp;
    rdata_ready = 1'b0;
    send_cmd(1'b0, 24'h000200, 9'd14);
    checks++;
    if ({sdrd_bytes, sdram_rd_addr} !== {9'd14, 24'h000200}) begin
      errors++;
      $display("FAIL rd_latch: got bytes=%0d addr=%h expected bytes=14 addr=000200",
               sdrd_bytes, sdram_rd_addr);
    end
    wait_req(1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rd_fill_timeout: got req=%b expected 1", sdram_rd_req);
    end
    for (int i = 0; i < 14; i++) begin
      sdram_rd_ack  = 1'b1;
      sdram_rd_data = 16'h9000 + 16'(i);
      tick();
      if (i == 0) begin
        checks++;
        if ({rdata_valid, rdata} !== {1'b1, 16'h9000}) begin
          errors++;
          $display("FAIL rd_first: got valid=%b data=%h expected 1 9000", rdata_valid, rdata);
        end
      end
    end
    sdram_rd_ack = 1'b0;
    tick();
    send_cmd(1'b0, 24'h000300, 9'd4);
    tick();
    tick();
    tick();
    checks++;
    if ({sdram_rd_req, cmd_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rspace_wait: got req=%b ready=%b expected 0 0", sdram_rd_req, cmd_ready);
    end
    rdata_ready = 1'b1;
    #1;
    checks++;
    if (rdata !== 16'h9000) begin
      errors++;
      $display("FAIL pop0: got %h expected 9000", rdata);
    end
    tick();
    checks++;
    if (rdata !== 16'h9001) begin
      errors++;
      $display("FAIL pop1: got %h expected 9001", rdata);
    end
    tick();
    rdata_ready = 1'b0;
    tick();
    checks++;
    if (sdram_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL rspace_release: got %b expected 1", sdram_rd_req);
    end
    for (int i = 0; i < 4; i++) begin
      sdram_rd_ack  = 1'b1;
      sdram_rd_data = 16'hB001 + 16'(i);
      tick();
    end
    sdram_rd_ack = 1'b0;
    tick();
    rdata_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 12) ? 16'h9002 + 16'(i) : 16'hB001 + 16'(i - 12);
      #1;
      checks++;
      if ({rdata_valid, rdata} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL drain_%0d: got valid=%b data=%h expected 1 %h", i, rdata_valid, rdata, exp);
      end
      tick();
    end
    rdata_ready = 1'b0;
    checks++;
    if (rdata_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got %b expected 0", rdata_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic ok;
    push_word(16'hE001);
    send_cmd(1'b0, 24'h000400, 9'd4);
    wait_req(1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_rd_timeout: got req=%b expected 1", sdram_rd_req);
    end
    sdram_rd_ack  = 1'b1;
    sdram_rd_data = 16'hD001;
    tick();
    sdram_rd_data = 16'hD002;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sdram_rd_ack = 1'b0;
    #1;
    checks++;
    if ({sdram_wr_req, sdram_rd_req, rdata_valid, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid: got wreq=%b rreq=%b rvalid=%b ready=%b expected 0 0 0 1",
               sdram_wr_req, sdram_rd_req, rdata_valid, cmd_ready);
    end
    send_cmd(1'b1, 24'h000500, 9'd1);
    tick();
    tick();
    tick();
    checks++;
    if (sdram_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_wfifo_empty: got req=%b expected 0", sdram_wr_req);
    end
    push_word(16'hE002);
    wait_req(1'b1, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_timeout: got req=%b expected 1", sdram_wr_req);
    end
    sdram_wr_ack = 1'b1;
    #1;
    checks++;
    if (sdram_wr_data !== 16'hE002) begin
      errors++;
      $display("FAIL rst_wr_data: got %h expected E002", sdram_wr_data);
    end
    tick();
    sdram_wr_ack = 1'b0;
    tick();
  endtask

  task automatic test_page_check();
    logic ok;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(16'hF001 + 16'(i));
    send_cmd(1'b1, 24'h0001FE, 9'd4);
`ifdef SDRAM_BRIDGE_PAGE_CHECK_EN
    checks++;
    if ({err, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL page_err: got err=%b ready=%b expected 1 1", err, cmd_ready);
    end
    tick();
    tick();
    checks++;
    if (sdram_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL page_req: got %b expected 0", sdram_wr_req);
    end
`else
    checks++;
    if (sdwr_bytes !== 9'd4) begin
      errors++;
      $display("FAIL page_bytes: got %0d expected 4", sdwr_bytes);
    end
    wait_req(1'b1, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL page_req: got req=%b expected 1", sdram_wr_req);
    end
    for (int i = 0; i < 4; i++) begin
      sdram_wr_ack = 1'b1;
      #1;
      checks++;
      if (sdram_wr_data !== 16'hF001 + 16'(i)) begin
        errors++;
        $display("FAIL page_data_%0d: got %h expected %h", i, sdram_wr_data, 16'hF001 + 16'(i));
      end
      tick();
    end
    sdram_wr_ack = 1'b0;
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL page_noerr: got %b expected 0", err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_not_ready();
    test_write_burst();
    test_illegal_len();
    test_extra_acks();
    test_read_full();
    test_reset_mid_burst();
    test_page_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
